// File: rtl/ss_apb_timeout_bridge.sv
// APB pass-through bridge that forces a PSLVERR response when the downstream slave never completes.
// Optional macro SS_APB_ERR_ADDR_CAPTURE_EN adds a register holding the address of the last timeout.
module ss_apb_timeout_bridge #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic [ADDR_W-1:0] s_paddr,
    input  logic              s_psel,
    input  logic              s_penable,
    input  logic              s_pwrite,
    input  logic [DATA_W-1:0] s_pwdata,
    output logic [DATA_W-1:0] s_prdata,
    output logic              s_pready,
    output logic              s_pslverr,
    output logic [ADDR_W-1:0] m_paddr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [DATA_W-1:0] m_pwdata,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr,
    input  logic              ss_en,
    input  logic              irq_en,
    input  logic              irq_clr,
    output logic              timeout_irq,
    output logic [7:0]        timeout_count,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_sticky;
    logic [7:0]        r_tcount;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              w_start;
    logic              w_timeout;
    logic              w_resp;

    // Handshake: a transfer starts on an upstream setup phase (psel=1, penable=0) seen in IDLE;
    // it completes when s_pready pulses for exactly one cycle, and downstream completes on m_pready.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    w_start = 1'b1;
                    w_next  = ss_en ? M_SETUP : RESP;
                end
            end
            M_SETUP: w_next = M_ACCESS;
            M_ACCESS: begin
                if (m_pready) begin
                    w_next = RESP;
                end else if (r_cnt == LP_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Response data is prepared before RESP so the upstream outputs come straight from registers.
    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else begin
            if (w_start) begin
                r_paddr  <= s_paddr;
                r_pwrite <= s_pwrite;
                r_pwdata <= s_pwdata;
                r_rdata  <= ERR_DATA;
                r_err    <= 1'b1;
            end
            if (r_state == M_SETUP) begin
                r_cnt <= '0;
            end
            if (r_state == M_ACCESS) begin
                if (m_pready) begin
                    r_err <= m_pslverr;
                    if (m_pslverr) begin
                        r_rdata <= ERR_DATA;
                    end else if (r_pwrite) begin
                        r_rdata <= '0;
                    end else begin
                        r_rdata <= m_prdata;
                    end
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= ERR_DATA;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    // A timeout in the same cycle as irq_clr keeps the flag set.
    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            r_sticky <= 1'b0;
            r_tcount <= '0;
        end else begin
            if (w_timeout) begin
                r_sticky <= 1'b1;
            end else if (irq_clr) begin
                r_sticky <= 1'b0;
            end
            if (w_timeout && (r_tcount != 8'hFF)) begin
                r_tcount <= r_tcount + 8'd1;
            end
        end
    end

`ifdef SS_APB_ERR_ADDR_CAPTURE_EN
    logic [ADDR_W-1:0] r_err_addr;

    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            r_err_addr <= '0;
        end else if (w_timeout) begin
            r_err_addr <= r_paddr;
        end
    end

    assign err_addr = r_err_addr;
`else
    assign err_addr = '0;
`endif

    assign w_resp        = (r_state == RESP);
    assign s_pready      = w_resp;
    assign s_pslverr     = w_resp & r_err;
    assign s_prdata      = w_resp ? r_rdata : '0;
    assign m_psel        = (r_state == M_SETUP) || (r_state == M_ACCESS);
    assign m_penable     = (r_state == M_ACCESS);
    assign m_paddr       = r_paddr;
    assign m_pwrite      = r_pwrite;
    assign m_pwdata      = r_pwdata;
    assign timeout_irq   = r_sticky & irq_en;
    assign timeout_count = r_tcount;

endmodule

// File: tb/tb_ss_apb_timeout_bridge.sv
// Bench for ss_apb_timeout_bridge: per-transfer timeline model (latency, bus phases, response,
// timeout flag/count) compared against the DUT on every cycle, plus directed literal checks.
module tb_ss_apb_timeout_bridge;

  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk_in = 1'b0;
  logic        reset_int;
  logic [31:0] s_paddr;
  logic        s_psel;
  logic        s_penable;
  logic        s_pwrite;
  logic [31:0] s_pwdata;
  logic [31:0] s_prdata;
  logic        s_pready;
  logic        s_pslverr;
  logic [31:0] m_paddr;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;
  logic        ss_en;
  logic        irq_en;
  logic        irq_clr;
  logic        timeout_irq;
  logic [7:0]  timeout_count;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  int          exp_count = 0;
  bit          exp_sticky = 1'b0;
  logic [31:0] exp_err_addr = '0;

  ss_apb_timeout_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clk_in(clk_in), .reset_int(reset_int),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .ss_en(ss_en), .irq_en(irq_en), .irq_clr(irq_clr),
    .timeout_irq(timeout_irq), .timeout_count(timeout_count), .err_addr(err_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_err_addr_out();
`ifdef SS_APB_ERR_ADDR_CAPTURE_EN
    return exp_err_addr;
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk_status();
    chk("timeout_count", {56'h0, timeout_count}, 64'(exp_count));
    chk("timeout_irq", {63'h0, timeout_irq}, {63'h0, exp_sticky & irq_en});
    chk("err_addr", {32'h0, err_addr}, {32'h0, exp_err_addr_out()});
  endtask

  // Caller is positioned just after a rising edge with the DUT idle.
  // waits >= TO means the downstream never answers.
  task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         input bit en, input int waits, input logic [31:0] rdata,
                         input bit serr, input bit ien, input int clr_at);
    bit is_to;
    int lat;
    bit exp_err;
    logic [31:0] exp_data;
    is_to = en && (waits >= TO);
    if (!en) lat = 1;
    else if (is_to) lat = TO + 2;
    else lat = 3 + waits;
    exp_err  = !en || is_to || serr;
    exp_data = exp_err ? ERR : (wr ? 32'h0 : rdata);
    ss_en  = en;
    irq_en = ien;
    for (int c = 0; c <= lat + 1; c++) begin
      s_paddr   = (c == 0) ? addr : $urandom;
      s_pwrite  = (c == 0) ? wr : 1'($urandom_range(0, 1));
      s_pwdata  = (c == 0) ? wdata : $urandom;
      s_psel    = (c <= lat);
      s_penable = (c >= 1) && (c <= lat);
      m_pready  = en && !is_to && (c == 2 + waits);
      m_prdata  = m_pready ? rdata : $urandom;
      m_pslverr = m_pready ? serr : 1'($urandom_range(0, 1));
      irq_clr   = (c == clr_at);
      if (c >= 1) ss_en = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      if (c >= 1 && (c - 1) == clr_at) exp_sticky = 1'b0;
      if (is_to && c == lat) begin
        exp_sticky = 1'b1;
        if (exp_count < 255) exp_count++;
        exp_err_addr = addr;
      end
      chk("s_pready", {63'h0, s_pready}, {63'h0, c == lat});
      chk("s_pslverr", {63'h0, s_pslverr}, {63'h0, (c == lat) && exp_err});
      chk("s_prdata", {32'h0, s_prdata}, {32'h0, (c == lat) ? exp_data : 32'h0});
      chk("m_psel", {63'h0, m_psel}, {63'h0, en && c >= 1 && c < lat});
      chk("m_penable", {63'h0, m_penable}, {63'h0, en && c >= 2 && c < lat});
      if (c >= 1) begin
        chk("m_paddr", {32'h0, m_paddr}, {32'h0, addr});
        chk("m_pwrite", {63'h0, m_pwrite}, {63'h0, wr});
        chk("m_pwdata", {32'h0, m_pwdata}, {32'h0, wdata});
      end
      chk_status();
      @(posedge clk_in);
      #1;
    end
    irq_clr  = 1'b0;
    m_pready = 1'b0;
  endtask

  initial begin
    reset_int = 1'b1;
    s_paddr = '0; s_psel = 0; s_penable = 0; s_pwrite = 0; s_pwdata = '0;
    m_prdata = '0; m_pready = 0; m_pslverr = 0;
    ss_en = 0; irq_en = 0; irq_clr = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_s_pready", {63'h0, s_pready}, 64'h0);
    chk("rst_m_psel", {63'h0, m_psel}, 64'h0);
    chk("rst_m_paddr", {32'h0, m_paddr}, 64'h0);
    chk("rst_count", {56'h0, timeout_count}, 64'h0);
    @(posedge clk_in); #1;
    reset_int = 1'b0;
    @(posedge clk_in); #1;

    // Directed cases from the plan.
    do_xfer(32'h0000_0010, 0, 32'h0, 1, 0, 32'h1234_5678, 0, 1, -1);
    do_xfer(32'h0000_0004, 1, 32'hA5A5_0001, 1, 3, 32'h0, 0, 1, -1);
    do_xfer(32'h0000_0020, 0, 32'h0, 1, TO, 32'h0, 0, 1, -1);
    chk("lit_irq_after_to", {63'h0, timeout_irq}, 64'h1);
    chk("lit_count_after_to", {56'h0, timeout_count}, 64'h1);
    do_xfer(32'h0000_0030, 0, 32'h0, 1, TO - 1, 32'h0000_00FF, 0, 1, 0);
    chk("lit_irq_cleared", {63'h0, timeout_irq}, 64'h0);
    chk("lit_count_unchanged", {56'h0, timeout_count}, 64'h1);
    do_xfer(32'h0000_0040, 0, 32'h0, 0, 0, 32'h0, 0, 1, -1);
    do_xfer(32'h0000_0044, 0, 32'h0, 1, 1, 32'h0BAD_0BAD, 1, 1, -1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int w;
      case ($urandom_range(0, 5))
        0: w = TO - 1;
        1: w = TO;
        default: w = int'($urandom_range(0, 5));
      endcase
      do_xfer($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0, w,
              $urandom, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 25)));
    end

    // Asynchronous reset in the middle of a downstream access.
    ss_en = 1; irq_en = 1;
    s_paddr = 32'h0000_0050; s_pwrite = 1; s_pwdata = 32'h1111_2222; s_psel = 1; s_penable = 0;
    m_pready = 0;
    @(posedge clk_in); #1;
    s_penable = 1;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    reset_int = 1'b1;
    #1;
    exp_count = 0; exp_sticky = 0; exp_err_addr = '0;
    chk("arst_m_psel", {63'h0, m_psel}, 64'h0);
    chk("arst_m_penable", {63'h0, m_penable}, 64'h0);
    chk("arst_s_pready", {63'h0, s_pready}, 64'h0);
    chk("arst_m_paddr", {32'h0, m_paddr}, 64'h0);
    chk("arst_m_pwdata", {32'h0, m_pwdata}, 64'h0);
    chk("arst_m_pwrite", {63'h0, m_pwrite}, 64'h0);
    chk_status();
    s_psel = 0; s_penable = 0;
    @(posedge clk_in); #1;
    reset_int = 1'b0;
    @(posedge clk_in); #1;
    do_xfer(32'h0000_0060, 0, 32'h0, 1, 0, 32'hCAFE_F00D, 0, 1, -1);

    // Timeout coincident with irq_clr keeps the flag.
    do_xfer(32'h0000_0070, 0, 32'h0, 1, TO, 32'h0, 0, 1, -1);
    do_xfer(32'h0000_0074, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0);
    chk("lit_irq_clr_only", {63'h0, timeout_irq}, 64'h0);
    do_xfer(32'h0000_0078, 0, 32'h0, 1, TO, 32'h0, 0, 1, TO + 1);
    chk("lit_irq_clr_vs_to", {63'h0, timeout_irq}, 64'h1);

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++) begin
      do_xfer(32'h1000_0000 + 32'(i), 0, 32'h0, 1, TO, 32'h0, 0, 1, -1);
    end
    chk("lit_count_sat", {56'h0, timeout_count}, 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
